// File: rtl/ram_wr_rd_control_pkg.sv
// Shared types and defaults for the RAM fill / read-back controller.
// Holds the FSM state encoding, the default read-step period and the RAM geometry.
package ram_wr_rd_control_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    localparam int              CNT_W       = 24;
    localparam logic [CNT_W-1:0] CNT_MAX_DEF = 24'd9999999;
    localparam int              RAM_ADDR_W  = 8;
    localparam int              RAM_DATA_W  = 8;

endpackage

// File: rtl/ram_wr_rd_control_step_timer.sv
// Step timer: counts 0..CNT_MAX while enabled, holds otherwise, clears synchronously.
// tick marks the enabled cycle in which the count wraps.
module ram_wr_rd_control_step_timer
    import ram_wr_rd_control_pkg::*;
#(
    parameter logic [CNT_W-1:0] CNT_MAX = CNT_MAX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_max;

    assign at_max = (cnt_q == CNT_MAX);
    assign tick   = en && at_max;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = at_max ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ram_wr_rd_control.sv
// Fills a single-port RAM with an address-derived pattern, then reads it back one
// address per step period; key1 re-fills with the inverted pattern, key2 pauses reads.
module ram_wr_rd_control
    import ram_wr_rd_control_pkg::*;
#(
    parameter logic [CNT_W-1:0] CNT_MAX = CNT_MAX_DEF,
    parameter int               ADDR_W  = RAM_ADDR_W,
    parameter int               DATA_W  = RAM_DATA_W
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              key1_flag,
    input  logic              key2_flag,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_done,
    output logic              pattern_sel
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    function automatic logic [DATA_W-1:0] fill_word(input logic [ADDR_W-1:0] a,
                                                    input logic             inv);
        logic [DATA_W-1:0] w;
        w = DATA_W'(a);
        return inv ? ~w : w;
    endfunction

    state_t            state_q, state_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_done_q, wr_done_d;
    logic              pattern_sel_q, pattern_sel_d;
    logic              timer_en;
    logic              timer_clr;
    logic              step_tick;

    ram_wr_rd_control_step_timer #(
        .CNT_MAX (CNT_MAX)
    ) u_step_timer (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .en    (timer_en),
        .clr   (timer_clr),
        .tick  (step_tick)
    );

    always_comb begin
        state_d       = state_q;
        wr_en_d       = wr_en_q;
        rd_en_d       = rd_en_q;
        addr_d        = addr_q;
        wr_data_d     = wr_data_q;
        wr_done_d     = 1'b0;
        pattern_sel_d = pattern_sel_q;
        timer_en      = 1'b0;
        timer_clr     = 1'b0;

        // key1 outranks everything (including a simultaneous key2) once past IDLE
        if (key1_flag && (state_q != ST_IDLE)) begin
            pattern_sel_d = ~pattern_sel_q;
            state_d       = ST_WRITE;
            wr_en_d       = 1'b1;
            rd_en_d       = 1'b0;
            addr_d        = '0;
            wr_data_d     = fill_word('0, ~pattern_sel_q);
            timer_clr     = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_WRITE;
                    wr_en_d   = 1'b1;
                    rd_en_d   = 1'b0;
                    addr_d    = '0;
                    wr_data_d = fill_word('0, pattern_sel_q);
                    timer_clr = 1'b1;
                end
                ST_WRITE: begin
                    timer_clr = 1'b1;
                    if (addr_q == ADDR_LAST) begin
                        state_d   = ST_READ;
                        wr_en_d   = 1'b0;
                        rd_en_d   = 1'b1;
                        addr_d    = '0;
                        wr_done_d = 1'b1;
                    end else begin
                        addr_d    = addr_q + 1'b1;
                        wr_data_d = fill_word(addr_q + 1'b1, pattern_sel_q);
                    end
                end
                ST_READ: begin
                    // The pausing cycle does not advance the step count
                    if (key2_flag) begin
                        state_d = ST_PAUSE;
                    end else begin
                        timer_en = 1'b1;
                        if (step_tick) begin
                            addr_d = addr_q + 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (key2_flag) begin
                        state_d = ST_READ;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= ST_IDLE;
            wr_en_q       <= 1'b0;
            rd_en_q       <= 1'b0;
            addr_q        <= '0;
            wr_data_q     <= '0;
            wr_done_q     <= 1'b0;
            pattern_sel_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_en_q       <= wr_en_d;
            rd_en_q       <= rd_en_d;
            addr_q        <= addr_d;
            wr_data_q     <= wr_data_d;
            wr_done_q     <= wr_done_d;
            pattern_sel_q <= pattern_sel_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign rd_en       = rd_en_q;
    assign addr        = addr_q;
    assign wr_data     = wr_data_q;
    assign wr_done     = wr_done_q;
    assign pattern_sel = pattern_sel_q;

endmodule

// File: tb/tb_ram_wr_rd_control.sv
// Bench for ram_wr_rd_control: a fill/read-back reference model feeds a queue of
// expected per-cycle outputs that a separate monitor compares against the DUT.
module tb_ram_wr_rd_control;

    localparam logic [23:0] CNT_MAX = 24'd4;
    localparam int          STEP    = 5;
    localparam int          DEPTH   = 256;

    logic       clk;
    logic       rst_n;
    logic       key1;
    logic       key2;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] addr;
    logic [7:0] wr_data;
    logic       wr_done;
    logic       pattern_sel;

    ram_wr_rd_control #(
        .CNT_MAX (CNT_MAX),
        .ADDR_W  (8),
        .DATA_W  (8)
    ) dut (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .key1_flag   (key1),
        .key2_flag   (key2),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .addr        (addr),
        .wr_data     (wr_data),
        .wr_done     (wr_done),
        .pattern_sel (pattern_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr_en;
        logic       rd_en;
        logic [7:0] addr;
        logic [7:0] wr_data;
        logic       wr_done;
        logic       pat;
        logic [7:0] rdata;
    } snap_t;

    typedef enum {M_IDLE, M_FILL, M_READ, M_PAUSE} mode_t;

    snap_t      exp_q[$];
    int         check_cnt = 0;
    int         pass_cnt  = 0;
    int         done_seen = 0;
    int         done_exp  = 0;
    logic [7:0] ram       [DEPTH];
    logic [7:0] model_mem [DEPTH];

    mode_t mode;
    int    fill_idx;
    int    active;
    logic  pat;
    logic  done_next;

    task automatic check(input string name, input logic ok,
                         input logic [63:0] act, input logic [63:0] req);
        check_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
    endtask

    function automatic logic [7:0] fword(input int a, input logic p);
        logic [7:0] v;
        v = a[7:0];
        return p ? ~v : v;
    endfunction

    // Reference model: fill is an index 0..255, read address is elapsed step time / STEP
    task automatic model_reset();
        mode      = M_IDLE;
        fill_idx  = 0;
        active    = 0;
        pat       = 1'b0;
        done_next = 1'b0;
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        s.wr_en = 0; s.rd_en = 0; s.addr = 0; s.wr_data = 0;
        s.wr_done = 0; s.pat = pat; s.rdata = 0;
        case (mode)
            M_FILL: begin
                s.wr_en   = 1'b1;
                s.addr    = fill_idx[7:0];
                s.wr_data = fword(fill_idx, pat);
            end
            M_READ, M_PAUSE: begin
                s.rd_en   = 1'b1;
                s.addr    = 8'((active / STEP) % DEPTH);
                s.wr_done = done_next;
                s.rdata   = model_mem[s.addr];
            end
            default: ;
        endcase
        return s;
    endfunction

    task automatic model_step(input logic k1, input logic k2);
        done_next = 1'b0;
        if (mode == M_FILL) model_mem[fill_idx] = fword(fill_idx, pat);
        if (k1 && mode != M_IDLE) begin
            pat      = ~pat;
            mode     = M_FILL;
            fill_idx = 0;
        end else begin
            case (mode)
                M_IDLE: begin
                    mode     = M_FILL;
                    fill_idx = 0;
                end
                M_FILL: begin
                    if (fill_idx == DEPTH - 1) begin
                        mode      = M_READ;
                        active    = 0;
                        done_next = 1'b1;
                    end else begin
                        fill_idx++;
                    end
                end
                M_READ: begin
                    if (k2) mode = M_PAUSE;
                    else    active = (active + 1) % (DEPTH * STEP);
                end
                M_PAUSE: if (k2) mode = M_READ;
                default: ;
            endcase
        end
    endtask

    task automatic cycle(input logic k1, input logic k2);
        snap_t s;
        @(posedge clk);
        #1;
        s = model_snap();
        exp_q.push_back(s);
        if (s.wr_done) done_exp++;
        key1 = k1;
        key2 = k2;
        model_step(k1, k2);
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        key1  = 1'b0;
        key2  = 1'b0;
        model_reset();
        exp_q.push_back(model_snap());
        model_step(1'b0, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        key1 = 1'b0;
        key2 = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check({tag, "_async"}, {wr_en, rd_en, addr, wr_data, wr_done, pattern_sel} == 20'h0,
              64'({wr_en, rd_en, addr, wr_data, wr_done, pattern_sel}), 64'h0);
        @(posedge clk);
        #1;
        check({tag, "_hold"}, {wr_en, rd_en, addr, wr_data, wr_done, pattern_sel} == 20'h0,
              64'({wr_en, rd_en, addr, wr_data, wr_done, pattern_sel}), 64'h0);
        release_reset();
    endtask

    task automatic wait_mode(input mode_t m, input int budget, input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (mode == m) begin
                found = 1'b1;
                break;
            end
            cycle(1'b0, 1'b0);
        end
        check(name, found, 64'(found), 64'h1);
    endtask

    task automatic check_ram(input string name, input logic inv);
        int bad;
        int first_bad;
        bad = 0;
        first_bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ram[i] !== fword(i, inv)) begin
                if (bad == 0) first_bad = i;
                bad++;
            end
        end
        check(name, bad == 0, 64'({first_bad[7:0], ram[first_bad]}),
              64'({first_bad[7:0], fword(first_bad, inv)}));
    endtask

    // Monitor: pops one expectation per live cycle and keeps a RAM image from DUT writes
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (wr_en === 1'b1 && rd_en === 1'b1) begin
                check("wr_rd_exclusive", 1'b0, 64'({wr_en, rd_en}), 64'h0);
            end
            if (wr_done === 1'b1) done_seen++;
            if (exp_q.size() > 0) begin
                snap_t e;
                logic [7:0] act_d, req_d;
                e = exp_q.pop_front();
                act_d = e.wr_en ? wr_data : 8'h00;
                req_d = e.wr_en ? e.wr_data : 8'h00;
                check("outputs",
                      {wr_en, rd_en, addr, act_d, wr_done, pattern_sel} ===
                      {e.wr_en, e.rd_en, e.addr, req_d, e.wr_done, e.pat},
                      64'({wr_en, rd_en, addr, act_d, wr_done, pattern_sel}),
                      64'({e.wr_en, e.rd_en, e.addr, req_d, e.wr_done, e.pat}));
                if (e.rd_en && rd_en === 1'b1) begin
                    check("read_data", ram[addr] === e.rdata,
                          64'({addr, ram[addr]}), 64'({addr, e.rdata}));
                end
            end
            if (wr_en === 1'b1) ram[addr] = wr_data;
        end
    end

    initial begin
        logic found;
        rst_n = 1'b1;
        key1  = 1'b0;
        key2  = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        check("reset_state", {wr_en, rd_en, addr, wr_data, wr_done, pattern_sel} == 20'h0,
              64'({wr_en, rd_en, addr, wr_data, wr_done, pattern_sel}), 64'h0);
        @(posedge clk);
        #1;
        release_reset();

        // First fill and early read-back
        repeat (300) cycle(1'b0, 1'b0);
        check_ram("ram_after_fill0", 1'b0);

        // Run through a full address wrap and stop at addr 7, cnt 2
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (mode == M_READ && (active % STEP) == 2 && ((active / STEP) % DEPTH) == 7
                && i > 1000) begin
                found = 1'b1;
                break;
            end
            cycle(1'b0, 1'b0);
        end
        check("reach_pause_point", found, 64'(found), 64'h1);
        cycle(1'b0, 1'b1);
        repeat (50) cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        repeat (12) cycle(1'b0, 1'b0);

        // key1 in READ: inverted fill
        cycle(1'b1, 1'b0);
        repeat (265) cycle(1'b0, 1'b0);
        check_ram("ram_after_fill1", 1'b1);

        // key1 mid-fill at addr 100
        cycle(1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (mode == M_FILL && fill_idx == 100) begin
                found = 1'b1;
                break;
            end
            cycle(1'b0, 1'b0);
        end
        check("reach_fill100", found, 64'(found), 64'h1);
        cycle(1'b1, 1'b0);
        repeat (270) cycle(1'b0, 1'b0);
        check_ram("ram_after_abort", 1'b1);

        // key1 and key2 together in READ
        wait_mode(M_READ, 300, "reach_read_k12");
        repeat (3) cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b1);
        repeat (270) cycle(1'b0, 1'b0);

        // Reset in PAUSE, mid-WRITE and mid-READ
        wait_mode(M_READ, 300, "reach_read_pause");
        cycle(1'b0, 1'b1);
        repeat (5) cycle(1'b0, 1'b0);
        do_reset("rst_pause");
        repeat (40) cycle(1'b0, 1'b0);
        do_reset("rst_write");
        repeat (300) cycle(1'b0, 1'b0);
        do_reset("rst_read");
        repeat (300) cycle(1'b0, 1'b0);
        check_ram("ram_after_resets", 1'b0);

        // Randomized key traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 399) == 0, $urandom_range(0, 39) == 0);
        end

        key1 = 1'b0;
        key2 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size() == 0, 64'(exp_q.size()), 64'h0);
        check("wr_done_count", done_seen == done_exp, 64'(done_seen), 64'(done_exp));
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
